// File: rtl/lfu_lights.sv
// lfu_lights: five-item least-frequently-used tracker for a front-panel demo.
// Each button requests one item; lit lights show which items are resident.
// When the tracker is full, a request for an absent item evicts the resident
// item with the smallest use count (lowest index wins ties).
module lfu_lights #(
    parameter int CAPACITY = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic b5,
    output logic l1,
    output logic l2,
    output logic l3,
    output logic l4,
    output logic l5
);

    localparam int               N       = 5;
    localparam logic [2:0]       CAP_V   = 3'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating increment: a counter at full scale stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Population count of a five-bit vector.
    function automatic logic [2:0] popcnt5(input logic [N-1:0] v);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + {2'b00, v[i]};
        end
        return s;
    endfunction

    logic [N-1:0]     r_res;
    logic [CNT_W-1:0] r_cnt [N];

    logic [N-1:0]     w_btn;
    logic             w_valid;
    logic             w_hit;
    logic             w_full;
    logic [N-1:0]     w_vic_oh;
    logic [CNT_W-1:0] w_vic_cnt;
    logic             w_vic_found;
    logic [N-1:0]     w_res_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [N];

    // Bit i of the internal vectors corresponds to item i+1.
    assign w_btn   = {b5, b4, b3, b2, b1};
    assign w_valid = (popcnt5(w_btn) == 3'd1);
    assign w_hit   = ((w_btn & r_res) != '0);
    assign w_full  = (popcnt5(r_res) >= CAP_V);

    // Victim search: strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_vic_oh    = '0;
        w_vic_cnt   = CNT_MAX;
        w_vic_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_res[i] && (!w_vic_found || (r_cnt[i] < w_vic_cnt))) begin
                w_vic_oh    = '0;
                w_vic_oh[i] = 1'b1;
                w_vic_cnt   = r_cnt[i];
                w_vic_found = 1'b1;
            end
        end
    end

    // Next-state: hit bumps the count; miss inserts, evicting the victim first when full.
    always_comb begin
        w_res_nxt = r_res;
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        if (w_valid) begin
            if (w_hit) begin
                for (int i = 0; i < N; i++) begin
                    if (w_btn[i]) begin
                        w_cnt_nxt[i] = sat_inc(r_cnt[i]);
                    end
                end
            end else begin
                if (w_full) begin
                    for (int i = 0; i < N; i++) begin
                        if (w_vic_oh[i]) begin
                            w_res_nxt[i] = 1'b0;
                            w_cnt_nxt[i] = '0;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (w_btn[i]) begin
                        w_res_nxt[i] = 1'b1;
                        w_cnt_nxt[i] = CNT_ONE;
                    end
                end
            end
        end
    end

    // State register; reset clears residency and all use history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_res <= w_res_nxt;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign l1 = r_res[0];
    assign l2 = r_res[1];
    assign l3 = r_res[2];
    assign l4 = r_res[3];
    assign l5 = r_res[4];

endmodule

// File: tb/tb_lfu_lights.sv
// Bench for lfu_lights: three instances (default sizing, 2-bit counters,
// capacity 2) share one button stream. The driver pushes expected lights
// into a queue; a monitor pops one entry per clock and compares.
module tb_lfu_lights;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] b   = '0;     // b[4] = b1 ... b[0] = b5
    logic [4:0] la, lb, lc;   // la[4] = l1 ... la[0] = l5

    always #5 clk = ~clk;

    lfu_lights #(.CAPACITY(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst),
        .b1(b[4]), .b2(b[3]), .b3(b[2]), .b4(b[1]), .b5(b[0]),
        .l1(la[4]), .l2(la[3]), .l3(la[2]), .l4(la[1]), .l5(la[0])
    );

    lfu_lights #(.CAPACITY(4), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .b1(b[4]), .b2(b[3]), .b3(b[2]), .b4(b[1]), .b5(b[0]),
        .l1(lb[4]), .l2(lb[3]), .l3(lb[2]), .l4(lb[1]), .l5(lb[0])
    );

    lfu_lights #(.CAPACITY(2), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst),
        .b1(b[4]), .b2(b[3]), .b3(b[2]), .b4(b[1]), .b5(b[0]),
        .l1(lc[4]), .l2(lc[3]), .l3(lc[2]), .l4(lc[1]), .l5(lc[0])
    );

    // Reference model: one resident flag and one count per item per instance.
    int cap  [3] = '{4, 4, 2};
    int cmax [3] = '{255, 3, 3};
    bit m_res [3][5];
    int m_cnt [3][5];

    typedef struct {
        logic [4:0] ea;
        logic [4:0] eb;
        logic [4:0] ec;
    } exp_t;

    exp_t  expq [$];
    string tagq [$];

    int n_cmp = 0;
    int n_mis = 0;

    function automatic void model_step(int inst, logic [4:0] bv, logic r);
        int n, k, nres, vic;
        if (r) begin
            for (int i = 0; i < 5; i++) begin
                m_res[inst][i] = 1'b0;
                m_cnt[inst][i] = 0;
            end
            return;
        end
        n = 0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (bv[4-i]) begin
                n++;
                k = i;
            end
        end
        if (n != 1) return;
        if (m_res[inst][k]) begin
            if (m_cnt[inst][k] < cmax[inst]) m_cnt[inst][k]++;
            return;
        end
        nres = 0;
        for (int i = 0; i < 5; i++) if (m_res[inst][i]) nres++;
        if (nres >= cap[inst]) begin
            vic = -1;
            for (int i = 0; i < 5; i++) begin
                if (m_res[inst][i] && (vic < 0 || m_cnt[inst][i] < m_cnt[inst][vic])) vic = i;
            end
            m_res[inst][vic] = 1'b0;
            m_cnt[inst][vic] = 0;
        end
        m_res[inst][k] = 1'b1;
        m_cnt[inst][k] = 1;
    endfunction

    function automatic logic [4:0] model_lights(int inst);
        logic [4:0] v;
        for (int i = 0; i < 5; i++) v[4-i] = m_res[inst][i];
        return v;
    endfunction

    // One clock of stimulus. Directed steps use the hand-derived light pattern
    // for the two capacity-4 instances; the capacity-2 instance always uses the model.
    task automatic drive(input logic [4:0] bv, input logic r, input logic [4:0] exp_ab,
                         input bit directed, input string tag);
        exp_t e;
        @(negedge clk);
        b   = bv;
        rst = r;
        for (int inst = 0; inst < 3; inst++) model_step(inst, bv, r);
        e.ea = directed ? exp_ab : model_lights(0);
        e.eb = directed ? exp_ab : model_lights(1);
        e.ec = model_lights(2);
        expq.push_back(e);
        tagq.push_back(tag);
    endtask

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: lights=%b expected=%b", nm, act, expv);
        end
    endtask

    // Monitor: one expected entry per clock, sampled just after the rising edge.
    always @(posedge clk) begin
        exp_t  e;
        string t;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            check({t, "/cap4_w8"}, la, e.ea);
            check({t, "/cap4_w2"}, lb, e.eb);
            check({t, "/cap2_w2"}, lc, e.ec);
            check({t, "/cap2_pop"}, {4'b0000, ($countones(lc) <= 2)}, 5'b00001);
        end
    end

    task automatic fill_to_11110();
        repeat (3) drive(5'b10000, 1'b0, 5'b10000, 1'b1, "fill_b1");
        repeat (3) drive(5'b01000, 1'b0, 5'b11000, 1'b1, "fill_b2");
        repeat (3) drive(5'b00100, 1'b0, 5'b11100, 1'b1, "fill_b3");
        repeat (2) drive(5'b00010, 1'b0, 5'b11110, 1'b1, "fill_b4");
    endtask

    initial begin
        logic [4:0] bv;
        logic       r;
        int         sel;

        // Reset then idle
        drive(5'b00000, 1'b1, 5'b00000, 1'b1, "reset");
        repeat (5) drive(5'b00000, 1'b0, 5'b00000, 1'b1, "idle");

        // Fill in order, then LFU eviction of item 4
        fill_to_11110();
        drive(5'b00001, 1'b0, 5'b11101, 1'b1, "evict_lfu");

        // Multi-press burst must leave state and counts untouched
        drive(5'b00000, 1'b1, 5'b00000, 1'b1, "reset2");
        fill_to_11110();
        repeat (1000) drive(5'b11111, 1'b0, 5'b11110, 1'b1, "multi_press");
        drive(5'b00001, 1'b0, 5'b11101, 1'b1, "multi_then_b5");

        // Tie-break: all counts 1, lowest index goes
        drive(5'b00000, 1'b1, 5'b00000, 1'b1, "reset3");
        drive(5'b10000, 1'b0, 5'b10000, 1'b1, "tie_b1");
        drive(5'b01000, 1'b0, 5'b11000, 1'b1, "tie_b2");
        drive(5'b00100, 1'b0, 5'b11100, 1'b1, "tie_b3");
        drive(5'b00010, 1'b0, 5'b11110, 1'b1, "tie_b4");
        drive(5'b00001, 1'b0, 5'b01111, 1'b1, "tie_b5");

        // Saturation: item 1 hammered, item 2 is the victim
        drive(5'b00000, 1'b1, 5'b00000, 1'b1, "reset4");
        repeat (10) drive(5'b10000, 1'b0, 5'b10000, 1'b1, "sat_b1");
        drive(5'b01000, 1'b0, 5'b11000, 1'b1, "sat_b2");
        drive(5'b00100, 1'b0, 5'b11100, 1'b1, "sat_b3");
        drive(5'b00010, 1'b0, 5'b11110, 1'b1, "sat_b4");
        drive(5'b00001, 1'b0, 5'b10111, 1'b1, "sat_b5");

        // Mid-run reset wins over a simultaneous request; history is gone afterwards
        drive(5'b00100, 1'b1, 5'b00000, 1'b1, "mid_reset");
        drive(5'b00100, 1'b0, 5'b00100, 1'b1, "after_reset");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                bv = 5'b00000;
            end else if (sel == 1) begin
                bv = 5'($urandom);
                while ($countones(bv) < 2) bv = 5'($urandom);
            end else if ($urandom_range(0, 9) < 5) begin
                bv = 5'b10000 >> $urandom_range(0, 1);
            end else begin
                bv = 5'b10000 >> $urandom_range(0, 4);
            end
            drive(bv, r, 5'b00000, 1'b0, "random");
        end

        @(negedge clk);
        b = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (expq.size() != 0) begin
            n_mis++;
            $display("FAIL drain: pending=%0d expected=0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Watchdog: the run is bounded; an expiry is reported as a failure.
    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
